chunked_serial_adder: RTL and testbench



---
 rtl/chunked_serial_adder.sv | 140 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first,
// registered carry between chunks, valid/ready on both sides.
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             rst_q;

    logic [CHUNK-1:0] ac, bc, cs;
    logic             co_c;
    logic             msb_cin;
    logic             accept;

    // rst_q keeps in_ready low for every cycle that follows a reset edge
    assign in_ready  = (state_q == IDLE) && !rst_q;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        ac = '0;
        bc = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                ac = a_q[i*CHUNK +: CHUNK];
                bc = b_q[i*CHUNK +: CHUNK];
            end
        end
        {co_c, cs} = {1'b0, ac} + {1'b0, bc} + {{CHUNK{1'b0}}, carry_q};
        // carry into the MSB recovered from its sum bit
        msb_cin = cs[CHUNK-1] ^ ac[CHUNK-1] ^ bc[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = carryin ^ sub;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        acc_d[i*CHUNK +: CHUNK] = cs;
                    end
                end
                carry_d = co_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = co_c;
                    ovf_d   = msb_cin ^ co_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            rst_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (8/2, 4/4, 16/4)
// sharing one stimulus set, selected by sel.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic [15:0] ta = '0;
    logic [15:0] tb_b = '0;
    logic        tcin = 1'b0;
    logic        tsub = 1'b0;
    logic        tiv = 1'b0;
    logic        tor = 1'b0;

    logic        ir8, ov8, co8, of8;
    logic [7:0]  s8;
    logic        ir4, ov4, co4, of4;
    logic [3:0]  s4;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;

    logic        m_ir, m_ov, m_co, m_of;
    logic [15:0] m_sum;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) u8 (
        .clk(clk), .reset(reset),
        .in_valid(tiv && sel == 2'd0), .in_ready(ir8),
        .a(ta[7:0]), .b(tb_b[7:0]), .carryin(tcin), .sub(tsub),
        .out_valid(ov8), .out_ready(tor && sel == 2'd0),
        .sum(s8), .carryout(co8), .overflow(of8)
    );

    chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) u4 (
        .clk(clk), .reset(reset),
        .in_valid(tiv && sel == 2'd1), .in_ready(ir4),
        .a(ta[3:0]), .b(tb_b[3:0]), .carryin(tcin), .sub(tsub),
        .out_valid(ov4), .out_ready(tor && sel == 2'd1),
        .sum(s4), .carryout(co4), .overflow(of4)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .reset(reset),
        .in_valid(tiv && sel == 2'd2), .in_ready(ir16),
        .a(ta), .b(tb_b), .carryin(tcin), .sub(tsub),
        .out_valid(ov16), .out_ready(tor && sel == 2'd2),
        .sum(s16), .carryout(co16), .overflow(of16)
    );

    always_comb begin
        m_ir  = ir8;
        m_ov  = ov8;
        m_co  = co8;
        m_of  = of8;
        m_sum = {8'h00, s8};
        if (sel == 2'd1) begin
            m_ir  = ir4;
            m_ov  = ov4;
            m_co  = co4;
            m_of  = of4;
            m_sum = {12'h000, s4};
        end else if (sel == 2'd2) begin
            m_ir  = ir16;
            m_ov  = ov16;
            m_co  = co16;
            m_of  = of16;
            m_sum = s16;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !m_ir; k++) tick();
    endtask

    task automatic run_op(
        input  logic [15:0] a, input logic [15:0] b,
        input  logic cin, input logic sb, input int stall,
        output int lat, output logic [15:0] s,
        output logic co, output logic of, output logic ir_after
    );
        wait_ready();
        ta = a; tb_b = b; tcin = cin; tsub = sb; tiv = 1'b1;
        tick();
        tiv = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (m_ov) begin
                lat = k;
                break;
            end
        end
        s = m_sum; co = m_co; of = m_of;
        repeat (stall) tick();
        tor = 1'b1;
        tick();
        tor = 1'b0;
        ir_after = m_ir;
    endtask

    function automatic void model(
        input int w, input int ua, input int ub, input int cin, input int sb,
        output int s, output int co, output int of
    );
        int half, sa, sbv, r, u;
        half = 1 << (w - 1);
        sa  = (ua >= half) ? ua - (1 << w) : ua;
        sbv = (ub >= half) ? ub - (1 << w) : ub;
        if (sb == 0) begin
            u  = ua + ub + cin;
            co = (u >> w) & 1;
            r  = sa + sbv + cin;
        end else begin
            u  = ua - ub - cin;
            co = (ua >= ub + cin) ? 1 : 0;
            r  = sa - sbv - cin;
        end
        s  = u & ((1 << w) - 1);
        of = (r > half - 1 || r < -half) ? 1 : 0;
    endfunction

    task automatic test_reset();
        sel = 2'd0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (m_ir !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=0", m_ir);
        end
        checks++;
        if (m_ov !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b want=0", m_ov);
        end
        checks++;
        if ({m_sum, m_co, m_of} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b want=0", m_sum, m_co, m_of);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (m_ir !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=1", m_ir);
        end
    endtask

    task automatic test_vec(
        input string nm, input logic [7:0] a, input logic [7:0] b,
        input logic cin, input logic sb,
        input logic [7:0] es, input logic eco, input logic eof
    );
        int lat;
        logic [15:0] s;
        logic co, of, ira;
        sel = 2'd0;
        run_op({8'h00, a}, {8'h00, b}, cin, sb, 0, lat, s, co, of, ira);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL %s latency got=%0d want=4", nm, lat);
        end
        checks++;
        if (s !== {8'h00, es} || co !== eco || of !== eof) begin
            failures++;
            $display("FAIL %s result got=%h/%b/%b want=%h/%b/%b",
                     nm, s, co, of, es, eco, eof);
        end
        checks++;
        if (ira !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_after got=%b want=1", nm, ira);
        end
    endtask

    task automatic test_add_overflow();
        test_vec("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        test_vec("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        test_vec("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_carry_chain();
        test_vec("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int k;
        sel = 2'd0;
        wait_ready();
        ta = 16'h003C; tb_b = 16'h0045; tcin = 1'b0; tsub = 1'b0;
        tiv = 1'b1;
        tick();
        tiv = 1'b0;
        for (k = 0; k < 20 && !m_ov; k++) tick();
        checks++;
        if (m_ov !== 1'b1) begin
            failures++;
            $display("FAIL bp_out_valid_timeout got=%b want=1", m_ov);
        end
        for (int c = 0; c < 5; c++) begin
            tiv  = ~tiv;
            ta   = ta + 16'h0011;
            tb_b = tb_b ^ 16'h00A5;
            tick();
            checks++;
            if (m_ov !== 1'b1 || m_ir !== 1'b0 || m_sum !== 16'h0081 ||
                m_co !== 1'b0 || m_of !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold c=%0d got ov=%b ir=%b %h/%b/%b want 1 0 0081/0/1",
                         c, m_ov, m_ir, m_sum, m_co, m_of);
            end
        end
        tiv = 1'b0;
        tor = 1'b1;
        tick();
        tor = 1'b0;
        checks++;
        if (m_ir !== 1'b1 || m_ov !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ir=%b ov=%b want 1 0", m_ir, m_ov);
        end
        tick();
        checks++;
        if (m_ir !== 1'b1 || m_sum !== 16'h0081) begin
            failures++;
            $display("FAIL bp_no_accept got ir=%b sum=%h want 1 0081", m_ir, m_sum);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        logic [15:0] s;
        logic co, of, ira;
        sel = 2'd0;
        wait_ready();
        ta = 16'h00FF; tb_b = 16'h0001; tcin = 1'b1; tsub = 1'b0;
        tiv = 1'b1;
        tick();
        tiv = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (m_ov !== 1'b0 || m_ir !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags got ov=%b ir=%b want 0 0", m_ov, m_ir);
        end
        checks++;
        if ({m_sum, m_co, m_of} !== 18'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h/%b/%b want=0", m_sum, m_co, m_of);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (m_ir !== 1'b1 || m_ov !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release got ir=%b ov=%b want 1 0", m_ir, m_ov);
        end
        run_op(16'h0012, 16'h0034, 1'b0, 1'b0, 1, lat, s, co, of, ira);
        checks++;
        if (lat !== 4 || s !== 16'h0046 || co !== 1'b0 || of !== 1'b0) begin
            failures++;
            $display("FAIL midrst_fresh got lat=%0d %h/%b/%b want 4 0046/0/0",
                     lat, s, co, of);
        end
    endtask

    task automatic test_regress(input logic [1:0] which, input int w, input int n);
        int lat, es, eco, eof, ra, rb, rc, rs, st;
        logic [15:0] s;
        logic co, of, ira;
        sel = which;
        for (int i = 0; i < 1000; i++) begin
            ra = int'($urandom_range(0, (1 << w) - 1));
            rb = int'($urandom_range(0, (1 << w) - 1));
            rc = int'($urandom_range(0, 1));
            rs = int'($urandom_range(0, 1));
            st = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            model(w, ra, rb, rc, rs, es, eco, eof);
            run_op(16'(ra), 16'(rb), rc[0], rs[0], st, lat, s, co, of, ira);
            checks++;
            if (lat !== n || s !== 16'(es) || co !== eco[0] || of !== eof[0]) begin
                failures++;
                $display("FAIL regress_w%0d i=%0d a=%h b=%h c=%0d sub=%0d got lat=%0d %h/%b/%b want %0d %h/%0d/%0d",
                         w, i, ra, rb, rc, rs, lat, s, co, of, n, es, eco, eof);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_busy();
        test_regress(2'd1, 4, 1);
        test_regress(2'd2, 16, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
